accumulator_reader: RTL and testbench
=====================================

// Module: accumulator_reader
// PURPOSE
//  Drains the accumulator register bank into a word-serial stream.
//  - Snapshots the full DATA_WIDTH*COUNT vector on a load handshake.
//  - Emits one DATA_WIDTH word per valid/ready beat, with index and last flag.
//  - Feeds the activation/write-back path; frees the accumulator for the next MAC pass.
// PARAMETERS
//  DATA_WIDTH  32   width of one accumulator word
//  COUNT       128  words per snapshot; legal range >=1
//  IDX_W       $clog2(COUNT) (min 1), localparam; width of out_idx
// PORTS
//  clk         in   1               clock, rising edge
//  rst         in   1               synchronous reset, active-high
//  load_valid  in   1               acc_in holds a complete result
//  load_ready  out  1               reader idle, can take a snapshot
//  acc_in      in   DATA_WIDTH*COUNT accumulator vector; word i = [(i+1)*DW-1 : i*DW]
//  out_valid   out  1               out_data/out_idx/out_last valid
//  out_ready   in   1               downstream accepts the beat
//  out_data    out  DATA_WIDTH      current word
//  out_idx     out  IDX_W           index of current word, 0..COUNT-1
//  out_last    out  1               current word is index COUNT-1
//  busy        out  1               high in STREAM
//  done        out  1               1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, idx=0, out_valid=0, done=0, busy=0.
//    load_ready=1 from the first cycle after reset. Snapshot contents don't care.
//    Reset mid-STREAM aborts: no further beats, no done pulse.
//  - FSM has two states.
//    - IDLE: load_ready=1, out_valid=0.
//      On load_valid&load_ready, capture acc_in into the shadow register,
//      set idx=0 and go to STREAM.
//    - STREAM: load_ready=0, busy=1, out_valid=1.
//      out_data = shadow word[idx]; out_idx = idx; out_last = (idx==COUNT-1).
//      On a beat (out_valid&out_ready):
//        - idx<COUNT-1: idx++.
//        - idx==COUNT-1: go to IDLE, idx=0, done=1 for the next cycle only.
//  - Latency: word 0 is valid in the cycle after the load handshake.
//    At full throughput a snapshot takes COUNT cycles.
//  - Outputs are driven only from registers and the shadow mux.
//    No combinational path from out_ready or load_valid to any output.
//  - Backpressure: while out_valid & !out_ready, out_data, out_idx and out_last stay stable.
//  - Snapshot isolation: acc_in changes after the load handshake never affect the stream.
//  - load_valid during STREAM is ignored; it is not queued.
//    Earliest next load is the cycle in which done=1, since state is already IDLE.
//  - COUNT=1: a single beat with out_last=1 and out_idx=0, then done.
// CONFIGURATION
//  Macro ACC_READER_RELU_EN.
//  - Defined: out_data = 0 when the shadow word's MSB is 1, i.e. negative in
//    two's complement; otherwise the word is passed unchanged. Combinational on
//    the mux output, so latency is unchanged.
//  - Undefined: out_data is the raw shadow word, bit-exact.
// TESTING
//  - Reset/idle: rst=1 for 2 cycles, then release.
//    -> load_ready=1, out_valid=0, busy=0, done=0.
//  - Full drain: COUNT=4, DW=32, words 0..3 = 0x11,0x22,0x33,0x44, load, out_ready=1.
//    -> beats 0x11..0x44 on 4 consecutive cycles, idx 0..3, out_last only on idx 3,
//       done pulse on the next cycle.
//  - Backpressure: drop out_ready for 3 cycles on idx=1.
//    -> out_data=0x22 and idx=1 held; the stream resumes with no loss or duplicate.
//  - Isolation: change acc_in to all-0xFF and pulse load_valid during STREAM.
//    -> the stream still outputs the original words; no second snapshot.
//  - Reset mid-stream: rst=1 at idx=2.
//    -> next cycle out_valid=0, no done; a new load restarts at idx 0.
//  - RELU: word 0xFFFFFFF0 loaded.
//    -> with ACC_READER_RELU_EN out_data=0; without it out_data=0xFFFFFFF0.

Source files
------------

// File: rtl/accumulator_reader_if.sv
// Load/stream bus of the accumulator reader: snapshot handshake in, word stream out.
interface accumulator_reader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COUNT      = 128
);
  localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic                          load_valid;
  logic                          load_ready;
  logic [DATA_WIDTH*COUNT-1:0]   acc_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [IDX_W-1:0]              out_idx;
  logic                          out_last;

  // Producer/consumer side: offers snapshots, accepts beats.
  modport master (
    output load_valid,
    output acc_in,
    output out_ready,
    input  load_ready,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last
  );

  // Reader side.
  modport slave (
    input  load_valid,
    input  acc_in,
    input  out_ready,
    output load_ready,
    output out_valid,
    output out_data,
    output out_idx,
    output out_last
  );
endinterface

// File: rtl/accumulator_reader.sv
// Snapshots the accumulator bank on a load handshake and drains it as a
// word-serial valid/ready stream with index and last flag.
// Optional feature macro: ACC_READER_RELU_EN (zero negative words on output).
module accumulator_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COUNT      = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  accumulator_reader_if.slave  bus,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               done_q, done_d;
  logic [COUNT-1:0][DATA_WIDTH-1:0]   shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0]              word_c;

  // Control state with synchronous reset; aborts any stream in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Shadow copy of the accumulator; contents are irrelevant until loaded.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  // Next state: capture on load handshake, advance index on each accepted beat.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    shadow_d = shadow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          shadow_d = bus.acc_in;
          idx_d    = '0;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Current shadow word selected by the stream index.
  always_comb begin
    word_c = shadow_q[idx_q];
  end

  // Outputs decode only registered state and the shadow mux.
  always_comb begin
    bus.load_ready = (state_q == ST_IDLE);
    bus.out_valid  = (state_q == ST_STREAM);
    bus.out_idx    = idx_q;
    bus.out_last   = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
    busy           = (state_q == ST_STREAM);
    done           = done_q;
`ifdef ACC_READER_RELU_EN
    bus.out_data   = word_c[DATA_WIDTH-1] ? '0 : word_c;
`else
    bus.out_data   = word_c;
`endif
  end

endmodule

// File: tb/tb_accumulator_reader.sv
// Randomised and directed bench for accumulator_reader with a queue scoreboard.
module tb_accumulator_reader;

  localparam int unsigned DW  = 32;
  localparam int unsigned CNT = 4;
  localparam int unsigned IW  = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;

  accumulator_reader_if #(.DATA_WIDTH(DW), .COUNT(CNT)) bus ();

  accumulator_reader #(.DATA_WIDTH(DW), .COUNT(CNT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  beat_t q[$];
  logic  done_exp = 1'b0;
  logic  chk_en   = 1'b0;
  int    vectors  = 0;
  int    errors   = 0;

  function automatic logic [DW-1:0] ref_out(logic [DW-1:0] w);
`ifdef ACC_READER_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Scoreboard: compare visible outputs, then apply this edge's handshakes to the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("load_ready", 64'(bus.load_ready), 64'(q.size() == 0));
      check("out_valid",  64'(bus.out_valid),  64'(q.size() != 0));
      check("busy",       64'(busy),           64'(q.size() != 0));
      check("done",       64'(done),           64'(done_exp));
      if (q.size() != 0) begin
        check("out_data", 64'(bus.out_data), 64'(q[0].data));
        check("out_idx",  64'(bus.out_idx),  64'(q[0].idx));
        check("out_last", 64'(bus.out_last), 64'(q[0].last));
      end
      done_exp = 1'b0;
      if (rst) begin
        q.delete();
      end else if (q.size() != 0) begin
        if (bus.out_ready) begin
          beat_t b;
          b = q.pop_front();
          if (b.last) done_exp = 1'b1;
        end
      end else if (bus.load_valid) begin
        for (int i = 0; i < CNT; i++) begin
          q.push_back('{data: ref_out(bus.acc_in[i*DW +: DW]),
                        idx:  IW'(i),
                        last: (i == CNT - 1)});
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_words(logic [DW-1:0] w0, logic [DW-1:0] w1,
                           logic [DW-1:0] w2, logic [DW-1:0] w3);
    bus.acc_in = {w3, w2, w1, w0};
  endtask

  initial begin
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b0;
    bus.acc_in     = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);

    // Full drain at full throughput
    set_words(32'h11, 32'h22, 32'h33, 32'h44);
    bus.load_valid = 1'b1;
    bus.out_ready  = 1'b1;
    cyc(1);
    bus.load_valid = 1'b0;
    cyc(6);

    // Backpressure on idx 1 for three cycles
    bus.load_valid = 1'b1;
    cyc(1);
    bus.load_valid = 1'b0;
    cyc(1);
    bus.out_ready = 1'b0;
    cyc(3);
    bus.out_ready = 1'b1;
    cyc(5);

    // Snapshot isolation and ignored load during stream
    bus.load_valid = 1'b1;
    cyc(1);
    bus.load_valid = 1'b0;
    cyc(1);
    bus.acc_in     = '1;
    bus.load_valid = 1'b1;
    cyc(1);
    bus.load_valid = 1'b0;
    cyc(6);

    // Reset mid-stream at idx 2, then restart
    set_words(32'h11, 32'h22, 32'h33, 32'h44);
    bus.load_valid = 1'b1;
    cyc(1);
    bus.load_valid = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    bus.load_valid = 1'b1;
    cyc(1);
    bus.load_valid = 1'b0;
    cyc(6);

    // Negative word through the optional clamp
    set_words(32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0);
    bus.load_valid = 1'b1;
    cyc(1);
    bus.load_valid = 1'b0;
    cyc(6);

    // Random traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      bus.load_valid = ($urandom_range(2) == 0);
      bus.out_ready  = ($urandom_range(3) != 0);
      set_words($urandom, $urandom, $urandom, $urandom);
      rst = ($urandom_range(79) == 0);
      cyc(1);
    end

    // Bounded drain
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b1;
    for (int n = 0; n < 50 && q.size() != 0; n++) cyc(1);
    check("drain_timeout", 64'(q.size()), 64'd0);
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
